// File: rtl/serial_mag_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM state encoding
// and the one-hot {G,E,L} result codes.
package serial_mag_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] RES_G = 3'b100;
  localparam logic [2:0] RES_E = 3'b010;
  localparam logic [2:0] RES_L = 3'b001;

  // A comparison that never saw differing bits resolves to equal.
  function automatic logic [2:0] resolve_result(input logic decided,
                                                input logic [2:0] res);
    return decided ? res : RES_E;
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// Combinational 1-bit comparator cell: classifies one a/b bit pair.
module cmp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = a_bit & ~b_bit;
  assign lt = ~a_bit & b_bit;
  assign eq = ~(a_bit ^ b_bit);

endmodule

// File: rtl/serial_mag_cmp.sv
// Bit-serial, MSB-first magnitude comparator. The first differing bit pair
// decides the result; the full WIDTH bits are always consumed before done.
module serial_mag_cmp
  import serial_mag_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic G,
  output logic E,
  output logic L
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             decided;
  logic [2:0]       res_q;

  logic             gt;
  logic             eq;
  logic             lt;
  logic             dec_nxt;
  logic [2:0]       res_nxt;

  cmp_bit_cell u_cell (
    .a_bit (a_bit),
    .b_bit (b_bit),
    .gt    (gt),
    .eq    (eq),
    .lt    (lt)
  );

  // Only the first differing bit pair may set the result.
  always_comb begin
    dec_nxt = decided;
    res_nxt = res_q;
    if (!decided && !eq) begin
      dec_nxt = 1'b1;
      res_nxt = (gt ? RES_G : 3'b000) | (lt ? RES_L : 3'b000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      decided <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      G       <= 1'b0;
      E       <= 1'b0;
      L       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= SHIFT;
            cnt     <= '0;
            decided <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            cnt     <= cnt + CNT_W'(1);
            decided <= dec_nxt;
            if (cnt == LAST_BIT) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              {G, E, L} <= resolve_result(dec_nxt, res_nxt);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Pending result is qualified by decided, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      res_q <= RES_E;
    end else if (state == SHIFT && bit_valid) begin
      res_q <= res_nxt;
    end
  end

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Directed self-checking bench for serial_mag_cmp (WIDTH=8).
module tb_serial_mag_cmp;

  localparam int WIDTH = 8;
  localparam logic [2:0] EXP_G = 3'b100;
  localparam logic [2:0] EXP_E = 3'b010;
  localparam logic [2:0] EXP_L = 3'b001;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic done;
  logic G;
  logic E;
  logic L;

  int n_cmp = 0;
  int n_bad = 0;

  serial_mag_cmp #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .G         (G),
    .E         (E),
    .L         (L)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle 0 raises start with bit_valid and a junk pair (a=1,b=0) that would
  // decide "greater" if it were consumed in IDLE.
  task automatic run_cmp(input string name, input logic [7:0] a, input logic [7:0] b,
                         input bit gaps, input bit stray_start, input logic [2:0] exp_gel);
    @(posedge clk); #1;
    start = 1'b1; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    @(negedge clk);
    chk({name, "/idle_busy"}, 32'(busy), 32'd0);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (gaps && i != WIDTH - 1) begin
        @(posedge clk); #1;
        start = 1'b0; bit_valid = 1'b0; a_bit = 1'b1; b_bit = 1'b0;
        @(negedge clk);
        chk({name, "/gap_busy"}, 32'(busy), 32'd1);
        chk({name, "/gap_done"}, 32'(done), 32'd0);
      end
      @(posedge clk); #1;
      start = stray_start && (i == 4);
      bit_valid = 1'b1; a_bit = a[i]; b_bit = b[i];
      @(negedge clk);
      chk({name, "/shift_busy"}, 32'(busy), 32'd1);
      chk({name, "/shift_done"}, 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    start = stray_start; bit_valid = stray_start; a_bit = 1'b1; b_bit = 1'b0;
    @(negedge clk);
    chk({name, "/done"}, 32'(done), 32'd1);
    chk({name, "/done_busy"}, 32'(busy), 32'd0);
    chk({name, "/gel"}, 32'({G, E, L}), 32'(exp_gel));
    @(posedge clk); #1;
    start = 1'b0; bit_valid = 1'b0;
    @(negedge clk);
    chk({name, "/done_pulse"}, 32'(done), 32'd0);
    chk({name, "/after_busy"}, 32'(busy), 32'd0);
    chk({name, "/gel_hold"}, 32'({G, E, L}), 32'(exp_gel));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    #1;
    chk("reset_outputs", 32'({busy, done, G, E, L}), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // bit_valid alone in IDLE must not start anything
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
      @(negedge clk);
      chk("idle_valid_busy", 32'(busy), 32'd0);
      chk("idle_valid_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1; bit_valid = 1'b0;

    run_cmp("eq_a5",   8'hA5, 8'hA5, 1'b0, 1'b0, EXP_E);
    run_cmp("gt_80",   8'h80, 8'h7F, 1'b0, 1'b0, EXP_G);
    run_cmp("lt_3c",   8'h3C, 8'h3D, 1'b0, 1'b0, EXP_L);
    run_cmp("gt_gaps", 8'h01, 8'h00, 1'b1, 1'b0, EXP_G);
    run_cmp("stray",   8'h5A, 8'h5A, 1'b0, 1'b1, EXP_E);
    run_cmp("lt_7e",   8'h7E, 8'h7F, 1'b0, 1'b1, EXP_L);

    // Partial F0 vs 00 decides "greater" in 4 bits, then reset mid-SHIFT
    @(posedge clk); #1;
    start = 1'b1; bit_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      start = 1'b0; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    end
    @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    chk("pre_reset_gel", 32'({G, E, L}), 32'(EXP_L));
    @(posedge clk); #2;
    rst_n = 1'b0; bit_valid = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({busy, done, G, E, L}), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", 32'({busy, done, G, E, L}), 32'd0);

    run_cmp("rst_clean", 8'h10, 8'h20, 1'b0, 1'b0, EXP_L);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
